// File: rtl/qdma_master.sv
// QBUS DMA bus master: arbitrates for the bus, then runs one DATI or DATO
// word cycle per tenure with address/data setup timing and an NXM timeout.
module qdma_master #(
    parameter int ADDR_SETUP = 3,
    parameter int DOUT_SETUP = 2,
    parameter int TIMEOUT    = 200
) (
    input  logic clk,
    input  logic init,
    input  logic dma_read_req,
    input  logic dma_write_req,
    output logic dma_bus_master,
    output logic dma_complete,
    output logic dma_nxm,
    input  logic RDMG,
    input  logic RSYNC,
    input  logic RRPLY,
    output logic TDMR,
    output logic TSACK,
    output logic TDMGO,
    output logic TSYNC,
    output logic TDIN,
    output logic TDOUT,
    output logic TWTBT,
    output logic TADDR_EN,
    output logic TDATA_EN
);
    localparam int AC_W = (ADDR_SETUP < 1) ? 1 : $clog2(ADDR_SETUP + 1);
    localparam int DC_W = (DOUT_SETUP < 1) ? 1 : $clog2(DOUT_SETUP + 1);
    localparam int TC_W = (TIMEOUT < 1) ? 1 : $clog2(TIMEOUT + 1);
    localparam logic [AC_W-1:0] ADDR_LAST = AC_W'(ADDR_SETUP - 1);
    localparam logic [DC_W-1:0] DOUT_LAST = DC_W'(DOUT_SETUP - 1);
    localparam logic [TC_W-1:0] TO_LAST   = TC_W'(TIMEOUT - 1);

    typedef enum logic [3:0] {
        IDLE, REQ, WAIT_BUS, ADDR, SYNC, DATA, DONE, HOLD, RELEASE
    } state_t;

    state_t          state_reg, state_next;
    logic            is_read_reg, is_read_next;
    logic [AC_W-1:0] addr_cnt_reg, addr_cnt_next;
    logic [DC_W-1:0] dout_cnt_reg, dout_cnt_next;
    logic [TC_W-1:0] to_cnt_reg, to_cnt_next;
    logic            tdmr_reg, tdmr_next;
    logic            tsack_reg, tsack_next;
    logic            tsync_reg, tsync_next;
    logic            tdin_reg, tdin_next;
    logic            tdout_reg, tdout_next;
    logic            twtbt_reg, twtbt_next;
    logic            taddr_en_reg, taddr_en_next;
    logic            tdata_en_reg, tdata_en_next;
    logic            bus_master_reg, bus_master_next;
    logic            complete_reg, complete_next;
    logic            nxm_reg, nxm_next;

    always_ff @(posedge clk or posedge init) begin
        if (init) begin
            state_reg      <= IDLE;
            is_read_reg    <= 1'b0;
            addr_cnt_reg   <= '0;
            dout_cnt_reg   <= '0;
            to_cnt_reg     <= '0;
            tdmr_reg       <= 1'b0;
            tsack_reg      <= 1'b0;
            tsync_reg      <= 1'b0;
            tdin_reg       <= 1'b0;
            tdout_reg      <= 1'b0;
            twtbt_reg      <= 1'b0;
            taddr_en_reg   <= 1'b0;
            tdata_en_reg   <= 1'b0;
            bus_master_reg <= 1'b0;
            complete_reg   <= 1'b0;
            nxm_reg        <= 1'b0;
        end else begin
            state_reg      <= state_next;
            is_read_reg    <= is_read_next;
            addr_cnt_reg   <= addr_cnt_next;
            dout_cnt_reg   <= dout_cnt_next;
            to_cnt_reg     <= to_cnt_next;
            tdmr_reg       <= tdmr_next;
            tsack_reg      <= tsack_next;
            tsync_reg      <= tsync_next;
            tdin_reg       <= tdin_next;
            tdout_reg      <= tdout_next;
            twtbt_reg      <= twtbt_next;
            taddr_en_reg   <= taddr_en_next;
            tdata_en_reg   <= tdata_en_next;
            bus_master_reg <= bus_master_next;
            complete_reg   <= complete_next;
            nxm_reg        <= nxm_next;
        end
    end

    always_comb begin
        state_next      = state_reg;
        is_read_next    = is_read_reg;
        addr_cnt_next   = addr_cnt_reg;
        dout_cnt_next   = dout_cnt_reg;
        to_cnt_next     = to_cnt_reg;
        tdmr_next       = tdmr_reg;
        tsack_next      = tsack_reg;
        tsync_next      = tsync_reg;
        tdin_next       = tdin_reg;
        tdout_next      = tdout_reg;
        twtbt_next      = twtbt_reg;
        taddr_en_next   = taddr_en_reg;
        tdata_en_next   = tdata_en_reg;
        bus_master_next = bus_master_reg;
        complete_next   = 1'b0;
        nxm_next        = 1'b0;

        case (state_reg)
            IDLE: begin
                if (dma_read_req || dma_write_req) begin
                    state_next   = REQ;
                    tdmr_next    = 1'b1;
                    is_read_next = dma_read_req;
                end
            end
            REQ: begin
                // A withdrawn request wins over a simultaneous grant so the
                // grant falls through to TDMGO from IDLE.
                if (!(dma_read_req || dma_write_req)) begin
                    state_next = IDLE;
                    tdmr_next  = 1'b0;
                end else if (RDMG) begin
                    state_next = WAIT_BUS;
                    tsack_next = 1'b1;
                    tdmr_next  = 1'b0;
                end
            end
            WAIT_BUS: begin
                if (!RSYNC && !RRPLY) begin
                    state_next      = ADDR;
                    bus_master_next = 1'b1;
                    taddr_en_next   = 1'b1;
                    twtbt_next      = !is_read_reg;
                    addr_cnt_next   = '0;
                end
            end
            ADDR: begin
                if (addr_cnt_reg == ADDR_LAST) begin
                    state_next = SYNC;
                    tsync_next = 1'b1;
                end else begin
                    addr_cnt_next = addr_cnt_reg + 1'b1;
                end
            end
            SYNC: begin
                state_next    = DATA;
                taddr_en_next = 1'b0;
                twtbt_next    = 1'b0;
                tdin_next     = is_read_reg;
                tdata_en_next = !is_read_reg;
                to_cnt_next   = '0;
                dout_cnt_next = '0;
            end
            DATA: begin
                // A DATO reply only counts once TDOUT has been asserted.
                if (RRPLY && (is_read_reg || tdout_reg)) begin
                    state_next    = DONE;
                    complete_next = 1'b1;
                end else begin
                    if (!is_read_reg && !tdout_reg) begin
                        if (dout_cnt_reg == DOUT_LAST) begin
                            tdout_next = 1'b1;
                        end else begin
                            dout_cnt_next = dout_cnt_reg + 1'b1;
                        end
                    end
                    if (!RRPLY) begin
                        if (to_cnt_reg == TO_LAST) begin
                            state_next    = RELEASE;
                            nxm_next      = 1'b1;
                            tdin_next     = 1'b0;
                            tdout_next    = 1'b0;
                            tsync_next    = 1'b0;
                            tdata_en_next = 1'b0;
                        end else begin
                            to_cnt_next = to_cnt_reg + 1'b1;
                        end
                    end
                end
            end
            DONE: begin
                state_next = HOLD;
                tdin_next  = 1'b0;
                tdout_next = 1'b0;
            end
            HOLD: begin
                if (!RRPLY) begin
                    state_next    = RELEASE;
                    tsync_next    = 1'b0;
                    tdata_en_next = 1'b0;
                end
            end
            RELEASE: begin
                state_next      = IDLE;
                tsack_next      = 1'b0;
                bus_master_next = 1'b0;
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    assign TDMGO          = (state_reg == IDLE) && RDMG && !init;
    assign TDMR           = tdmr_reg;
    assign TSACK          = tsack_reg;
    assign TSYNC          = tsync_reg;
    assign TDIN           = tdin_reg;
    assign TDOUT          = tdout_reg;
    assign TWTBT          = twtbt_reg;
    assign TADDR_EN       = taddr_en_reg;
    assign TDATA_EN       = tdata_en_reg;
    assign dma_bus_master = bus_master_reg;
    assign dma_complete   = complete_reg;
    assign dma_nxm        = nxm_reg;

endmodule

// File: tb/tb_qdma_master.sv
// Self-checking bench for qdma_master: expected waveforms are derived from the
// bus-cycle timing rules (setup counts, reply handshake, timeout) per transfer.
module tb_qdma_master;
    localparam int ADDR_SETUP = 3;
    localparam int DOUT_SETUP = 2;
    localparam int TIMEOUT    = 200;

    logic clk = 1'b0;
    logic init = 1'b1;
    logic dma_read_req = 1'b0, dma_write_req = 1'b0;
    logic RDMG = 1'b0, RSYNC = 1'b0, RRPLY = 1'b0;
    logic dma_bus_master, dma_complete, dma_nxm;
    logic TDMR, TSACK, TDMGO, TSYNC, TDIN, TDOUT, TWTBT, TADDR_EN, TDATA_EN;

    int n_checks = 0;
    int n_fail   = 0;
    int n_cmp    = 0;
    int n_nxm    = 0;

    qdma_master #(
        .ADDR_SETUP(ADDR_SETUP),
        .DOUT_SETUP(DOUT_SETUP),
        .TIMEOUT   (TIMEOUT)
    ) dut (
        .clk           (clk),
        .init          (init),
        .dma_read_req  (dma_read_req),
        .dma_write_req (dma_write_req),
        .dma_bus_master(dma_bus_master),
        .dma_complete  (dma_complete),
        .dma_nxm       (dma_nxm),
        .RDMG          (RDMG),
        .RSYNC         (RSYNC),
        .RRPLY         (RRPLY),
        .TDMR          (TDMR),
        .TSACK         (TSACK),
        .TDMGO         (TDMGO),
        .TSYNC         (TSYNC),
        .TDIN          (TDIN),
        .TDOUT         (TDOUT),
        .TWTBT         (TWTBT),
        .TADDR_EN      (TADDR_EN),
        .TDATA_EN      (TDATA_EN)
    );

    always #25 clk = ~clk;

    // bus = {TSYNC,TDIN,TDOUT,TWTBT,TADDR_EN,TDATA_EN}
    wire [5:0] bus = {TSYNC, TDIN, TDOUT, TWTBT, TADDR_EN, TDATA_EN};
    wire [2:0] arb = {TDMR, TSACK, TDMGO};
    wire [2:0] sts = {dma_bus_master, dma_complete, dma_nxm};

    always @(negedge clk) begin
        if (dma_complete === 1'b1) n_cmp++;
        if (dma_nxm === 1'b1) n_nxm++;
        if (dma_complete === 1'b1 || dma_nxm === 1'b1) begin
            n_checks++;
            if (dma_complete === 1'b1 && dma_nxm === 1'b1) begin
                n_fail++;
                $display("FAIL pulse_exclusive complete=%b nxm=%b t=%0t", dma_complete, dma_nxm, $time);
            end
        end
    end

    initial begin
        #2000000;
        $display("FAIL watchdog simulation did not finish t=%0t", $time);
        $fatal(1, "watchdog");
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Drive a request through grant and setup until the DATA phase is entered.
    task automatic goto_data(input bit rd);
        dma_read_req  = rd;
        dma_write_req = !rd;
        tick();
        RDMG = 1'b1;
        tick();
        RDMG = 1'b0;
        dma_read_req  = 1'b0;
        dma_write_req = 1'b0;
        for (int i = 0; i < ADDR_SETUP + 2; i++) tick();
    endtask

    task automatic test_reset();
        RDMG = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        n_checks++;
        if ({arb, sts, bus} !== 12'b0) begin
            n_fail++;
            $display("FAIL reset_outputs got=%b exp=%b", {arb, sts, bus}, 12'b0);
        end
        RDMG = 1'b0;
        init = 1'b0;
        tick();
        n_checks++;
        if ({arb, sts, bus} !== 12'b0) begin
            n_fail++;
            $display("FAIL reset_release got=%b exp=%b", {arb, sts, bus}, 12'b0);
        end
    endtask

    task automatic run_transfer(input bit rd, input bit both, input int gd, input int busy,
                                input int rdly, input int hold, input bit rply_busy);
        logic [5:0] eb;
        int c0, x0;
        c0 = n_cmp;
        x0 = n_nxm;
        dma_read_req  = rd;
        dma_write_req = !rd || both;
        tick();
        n_checks++;
        if ({arb, sts, bus} !== {3'b100, 3'b000, 6'b0}) begin
            n_fail++;
            $display("FAIL req_phase got=%b exp=%b rd=%0d", {arb, sts, bus}, {3'b100, 3'b000, 6'b0}, rd);
        end
        for (int i = 0; i < gd; i++) begin
            tick();
            n_checks++;
            if (arb !== 3'b100) begin
                n_fail++;
                $display("FAIL req_wait arb got=%b exp=%b", arb, 3'b100);
            end
        end
        RDMG  = 1'b1;
        RSYNC = (busy > 0) && !rply_busy;
        RRPLY = (busy > 0) && rply_busy;
        tick();
        n_checks++;
        if ({arb, sts, bus} !== {3'b010, 3'b000, 6'b0}) begin
            n_fail++;
            $display("FAIL grant_accept got=%b exp=%b", {arb, sts, bus}, {3'b010, 3'b000, 6'b0});
        end
        RDMG = 1'b0;
        dma_read_req  = 1'($urandom_range(1, 0));
        dma_write_req = 1'($urandom_range(1, 0));
        for (int i = 0; i < busy; i++) begin
            tick();
            n_checks++;
            if ({arb, sts, bus} !== {3'b010, 3'b000, 6'b0}) begin
                n_fail++;
                $display("FAIL bus_busy got=%b exp=%b clk=%0d", {arb, sts, bus}, {3'b010, 3'b000, 6'b0}, i);
            end
        end
        RSYNC = 1'b0;
        RRPLY = 1'b0;
        eb = {3'b000, !rd, 2'b10};
        for (int i = 0; i < ADDR_SETUP; i++) begin
            tick();
            n_checks++;
            if ({sts, bus} !== {3'b100, eb}) begin
                n_fail++;
                $display("FAIL addr_phase got=%b exp=%b clk=%0d", {sts, bus}, {3'b100, eb}, i);
            end
        end
        tick();
        eb[5] = 1'b1;
        n_checks++;
        if (bus !== eb) begin
            n_fail++;
            $display("FAIL sync_assert got=%b exp=%b", bus, eb);
        end
        dma_read_req  = 1'b0;
        dma_write_req = 1'b0;
        tick();
        eb = {1'b1, rd, 1'b0, 1'b0, 1'b0, !rd};
        n_checks++;
        if (bus !== eb) begin
            n_fail++;
            $display("FAIL data_entry got=%b exp=%b", bus, eb);
        end
        for (int i = 1; i <= rdly; i++) begin
            tick();
            eb[3] = !rd && (i >= DOUT_SETUP);
            n_checks++;
            if ({sts, bus} !== {3'b100, eb}) begin
                n_fail++;
                $display("FAIL data_wait got=%b exp=%b clk=%0d", {sts, bus}, {3'b100, eb}, i);
            end
        end
        RRPLY = 1'b1;
        tick();
        eb[3] = !rd;
        n_checks++;
        if ({sts, bus} !== {3'b110, eb}) begin
            n_fail++;
            $display("FAIL done_pulse got=%b exp=%b", {sts, bus}, {3'b110, eb});
        end
        for (int j = 0; j < hold; j++) begin
            tick();
            n_checks++;
            if ({arb, sts, bus} !== {3'b010, 3'b100, 1'b1, 4'b0000, !rd}) begin
                n_fail++;
                $display("FAIL hold_phase got=%b exp=%b", {arb, sts, bus}, {3'b010, 3'b100, 1'b1, 4'b0000, !rd});
            end
        end
        RRPLY = 1'b0;
        tick();
        n_checks++;
        if ({arb, sts, bus} !== {3'b010, 3'b100, 6'b0}) begin
            n_fail++;
            $display("FAIL release_phase got=%b exp=%b", {arb, sts, bus}, {3'b010, 3'b100, 6'b0});
        end
        tick();
        n_checks++;
        if ({arb, sts, bus} !== 12'b0) begin
            n_fail++;
            $display("FAIL back_idle got=%b exp=%b", {arb, sts, bus}, 12'b0);
        end
        n_checks++;
        if (n_cmp - c0 !== 1 || n_nxm !== x0) begin
            n_fail++;
            $display("FAIL pulse_count complete=%0d nxm=%0d exp=1/0", n_cmp - c0, n_nxm - x0);
        end
        $display("xfer rd=%0d both=%0d gd=%0d busy=%0d rdly=%0d hold=%0d rbusy=%0d", rd, both, gd, busy, rdly, hold, rply_busy);
    endtask

    task automatic test_nxm(input bit rd);
        int n, c0, x0;
        c0 = n_cmp;
        x0 = n_nxm;
        goto_data(rd);
        n_checks++;
        if (bus !== {1'b1, rd, 1'b0, 1'b0, 1'b0, !rd}) begin
            n_fail++;
            $display("FAIL nxm_data_entry got=%b exp=%b", bus, {1'b1, rd, 1'b0, 1'b0, 1'b0, !rd});
        end
        n = 0;
        while (dma_nxm !== 1'b1 && n < TIMEOUT + 50) begin
            tick();
            n++;
        end
        n_checks++;
        if (n !== TIMEOUT) begin
            n_fail++;
            $display("FAIL nxm_latency got=%0d exp=%0d", n, TIMEOUT);
        end
        n_checks++;
        if ({arb, sts, bus} !== {3'b010, 3'b101, 6'b0}) begin
            n_fail++;
            $display("FAIL nxm_release got=%b exp=%b", {arb, sts, bus}, {3'b010, 3'b101, 6'b0});
        end
        tick();
        n_checks++;
        if ({arb, sts, bus} !== 12'b0 || n_cmp !== c0 || n_nxm - x0 !== 1) begin
            n_fail++;
            $display("FAIL nxm_after got=%b cmp=%0d nxm=%0d exp=0/0/1", {arb, sts, bus}, n_cmp - c0, n_nxm - x0);
        end
        $display("nxm rd=%0d latency=%0d", rd, n);
    endtask

    task automatic test_withdraw(input int linger);
        dma_read_req = 1'b1;
        tick();
        n_checks++;
        if (arb !== 3'b100) begin
            n_fail++;
            $display("FAIL withdraw_req got=%b exp=%b", arb, 3'b100);
        end
        for (int i = 0; i < linger; i++) tick();
        dma_read_req = 1'b0;
        tick();
        n_checks++;
        if ({arb, sts, bus} !== 12'b0) begin
            n_fail++;
            $display("FAIL withdraw_idle got=%b exp=%b", {arb, sts, bus}, 12'b0);
        end
        RDMG = 1'b1;
        #1;
        n_checks++;
        if ({arb, sts} !== {3'b001, 3'b000}) begin
            n_fail++;
            $display("FAIL passthru got=%b exp=%b", {arb, sts}, {3'b001, 3'b000});
        end
        tick();
        n_checks++;
        if ({arb, sts, bus} !== {3'b001, 3'b000, 6'b0}) begin
            n_fail++;
            $display("FAIL passthru_hold got=%b exp=%b", {arb, sts, bus}, {3'b001, 3'b000, 6'b0});
        end
        RDMG = 1'b0;
        #1;
        n_checks++;
        if (TDMGO !== 1'b0) begin
            n_fail++;
            $display("FAIL passthru_drop got=%b exp=0", TDMGO);
        end
        $display("withdraw linger=%0d", linger);
    endtask

    task automatic test_init_mid();
        int c0, x0;
        c0 = n_cmp;
        x0 = n_nxm;
        goto_data(1'b1);
        n_checks++;
        if (TDIN !== 1'b1) begin
            n_fail++;
            $display("FAIL init_pre_tdin got=%b exp=1", TDIN);
        end
        #10;
        init = 1'b1;
        #1;
        n_checks++;
        if ({arb, sts, bus} !== 12'b0) begin
            n_fail++;
            $display("FAIL init_async got=%b exp=%b", {arb, sts, bus}, 12'b0);
        end
        RRPLY = 1'b1;
        tick();
        tick();
        RRPLY = 1'b0;
        init = 1'b0;
        tick();
        tick();
        n_checks++;
        if ({arb, sts, bus} !== 12'b0 || n_cmp !== c0 || n_nxm !== x0) begin
            n_fail++;
            $display("FAIL init_after got=%b cmp=%0d nxm=%0d exp=0/0/0", {arb, sts, bus}, n_cmp - c0, n_nxm - x0);
        end
        $display("init mid-DATA");
    endtask

    initial begin
        test_reset();
        run_transfer(1'b1, 1'b0, 5, 0, 4, 2, 1'b0);
        run_transfer(1'b0, 1'b0, 2, 0, 3, 1, 1'b0);
        run_transfer(1'b1, 1'b0, 0, 10, 2, 1, 1'b0);
        run_transfer(1'b1, 1'b1, 1, 3, 0, 3, 1'b1);
        test_nxm(1'b1);
        test_nxm(1'b0);
        test_withdraw(0);
        test_withdraw(3);
        test_init_mid();
        run_transfer(1'b0, 1'b0, 0, 0, DOUT_SETUP, 1, 1'b0);
        for (int k = 0; k < 10; k++) begin
            bit rd;
            rd = 1'($urandom_range(1, 0));
            run_transfer(rd, 1'($urandom_range(1, 0)), $urandom_range(6, 0), $urandom_range(5, 0),
                         rd ? $urandom_range(8, 0) : $urandom_range(10, DOUT_SETUP),
                         $urandom_range(4, 1), 1'($urandom_range(1, 0)));
        end
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
